// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if -- handshake bundle between the control unit and the
// MULT/DIV sequencer.
//   control side : req, op, abort                  (control unit -> sequencer)
//   unit flags   : mult_done, div_done, div_by_zero (mul/div units -> sequencer)
//   outputs      : mult_start, div_start, hi_write, lo_write, hilo_src,
//                  busy, done, err, err_code        (sequencer -> everyone)
// slave  modport : the sequencer itself.
// master modport : whoever drives requests and completion flags.
interface muldiv_sequencer_if;
  logic       req;
  logic       op;
  logic       abort;
  logic       mult_done;
  logic       div_done;
  logic       div_by_zero;
  logic       mult_start;
  logic       div_start;
  logic       hi_write;
  logic       lo_write;
  logic       hilo_src;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  modport slave (
    input  req, op, abort, mult_done, div_done, div_by_zero,
    output mult_start, div_start, hi_write, lo_write, hilo_src,
           busy, done, err, err_code
  );

  modport master (
    output req, op, abort, mult_done, div_done, div_by_zero,
    input  mult_start, div_start, hi_write, lo_write, hilo_src,
           busy, done, err, err_code
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer -- sequences one MULT or DIV operation: start pulse,
// wait for the selected unit's done (with watchdog), then HI/LO write or
// error completion.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : muldiv_sequencer_if.slave (request, unit flags, all outputs)
//   TIMEOUT : WAIT cycles before the watchdog aborts (2..255)
// Every output is a flop (or the latched op), so nothing combinational
// reaches an output from an input.
module muldiv_sequencer #(
  parameter int TIMEOUT = 40
) (
  input  logic                   clk,
  input  logic                   reset,
  muldiv_sequencer_if.slave      bus
);

  typedef enum logic [2:0] {IDLE, START, WAIT, WRITE, ERR} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wd;
  logic       op_q;
  logic       mult_start_q, div_start_q, write_q, busy_q, done_q, err_q;
  logic [1:0] err_code_q;

  // Only the selected unit's completion flag is observed.
  logic sel_done;
  assign sel_done = op_q ? bus.div_done : bus.mult_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wd           <= '0;
      op_q         <= 1'b0;
      err_code_q   <= 2'b00;
      mult_start_q <= 1'b0;
      div_start_q  <= 1'b0;
      write_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // Pulse outputs default low; each is raised only on entry to its state.
      mult_start_q <= 1'b0;
      div_start_q  <= 1'b0;
      write_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      if (state == IDLE) begin
        if (bus.req) begin
          op_q         <= bus.op;
          err_code_q   <= 2'b00;
          state        <= START;
          busy_q       <= 1'b1;
          mult_start_q <= !bus.op;
          div_start_q  <= bus.op;
        end
      end else if (bus.abort) begin
        // Abort beats done and timeout; err_code is left as it was.
        state  <= IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          START: begin
            wd    <= '0;
            state <= WAIT;
          end
          WAIT: begin
            if (sel_done) begin
              if (op_q && bus.div_by_zero) begin
                state      <= ERR;
                err_q      <= 1'b1;
                err_code_q <= 2'b01;
              end else begin
                state   <= WRITE;
                write_q <= 1'b1;
                done_q  <= 1'b1;
              end
            end else if (wd == WD_LAST) begin
              state      <= ERR;
              err_q      <= 1'b1;
              err_code_q <= 2'b10;
            end else begin
              wd <= wd + 8'd1;
            end
          end
          default: begin  // WRITE, ERR: one cycle, then back to IDLE
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.mult_start = mult_start_q;
  assign bus.div_start  = div_start_q;
  assign bus.hi_write   = write_q;
  assign bus.lo_write   = write_q;
  assign bus.hilo_src   = op_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer -- directed bench for muldiv_sequencer (TIMEOUT=8).
// Cycle n of a scenario is the cycle in which req is driven as n=0; inputs
// are driven and outputs sampled 1 time unit after each rising edge.
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_sequencer_if ifc ();

  muldiv_sequencer #(.TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  int checks = 0;
  int errors = 0;

  // Expected output word: {mult_start, div_start, hi_write, lo_write,
  // hilo_src, busy, done, err, err_code}.
  function automatic logic [9:0] e(bit ms, bit ds, bit wr, bit hs, bit bz,
                                   bit dn, bit er, logic [1:0] ec);
    return {ms, ds, wr, wr, hs, bz, dn, er, ec};
  endfunction

  task automatic chk(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    obs = {ifc.mult_start, ifc.div_start, ifc.hi_write, ifc.lo_write,
           ifc.hilo_src, ifc.busy, ifc.done, ifc.err, ifc.err_code};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset           = 1'b0;
    ifc.req         = 1'b0;
    ifc.op          = 1'b0;
    ifc.abort       = 1'b0;
    ifc.mult_done   = 1'b0;
    ifc.div_done    = 1'b0;
    ifc.div_by_zero = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_state", e(0,0,0,0,0,0,0,2'b00));
    @(negedge clk) reset = 1'b1;
    tick();
    chk("idle_after_reset", e(0,0,0,0,0,0,0,2'b00));

    // MULT, mult_done at cycle 5
    ifc.req = 1'b1; ifc.op = 1'b0;                    // c0
    tick(); ifc.req = 1'b0;                           // c1
    chk("mult_c1_start", e(1,0,0,0,1,0,0,2'b00));
    tick();                                           // c2
    chk("mult_c2_wait", e(0,0,0,0,1,0,0,2'b00));
    tick(); tick(); tick(); ifc.mult_done = 1'b1;     // c5
    chk("mult_c5_wait", e(0,0,0,0,1,0,0,2'b00));
    tick(); ifc.mult_done = 1'b0;                     // c6
    chk("mult_c6_write", e(0,0,1,0,1,1,0,2'b00));
    tick();                                           // c7
    chk("mult_c7_idle", e(0,0,0,0,0,0,0,2'b00));

    // DIV, divide-by-zero at cycle 4
    tick();
    ifc.req = 1'b1; ifc.op = 1'b1;                    // c0
    tick(); ifc.req = 1'b0; ifc.op = 1'b0;            // c1
    chk("dbz_c1_start", e(0,1,0,1,1,0,0,2'b00));
    tick(); tick(); tick();                           // c4
    ifc.div_done = 1'b1; ifc.div_by_zero = 1'b1;
    chk("dbz_c4_wait", e(0,0,0,1,1,0,0,2'b00));
    tick(); ifc.div_done = 1'b0; ifc.div_by_zero = 1'b0;  // c5
    chk("dbz_c5_err", e(0,0,0,1,1,0,1,2'b01));
    tick();                                           // c6
    chk("dbz_c6_idle", e(0,0,0,1,0,0,0,2'b01));
    repeat (3) tick();
    chk("dbz_code_held", e(0,0,0,1,0,0,0,2'b01));

    // DIV timeout with stray mult_done pulses
    ifc.req = 1'b1; ifc.op = 1'b1;                    // c0
    tick(); ifc.req = 1'b0; ifc.op = 1'b0;            // c1
    chk("tmo_c1_code_cleared", e(0,1,0,1,1,0,0,2'b00));
    tick(); tick(); ifc.mult_done = 1'b1;             // c3
    tick(); ifc.mult_done = 1'b0;                     // c4
    chk("tmo_c4_mult_done_ignored", e(0,0,0,1,1,0,0,2'b00));
    tick(); ifc.mult_done = 1'b1;                     // c5
    tick(); ifc.mult_done = 1'b0;                     // c6
    tick(); tick(); tick();                           // c9
    chk("tmo_c9_no_err_yet", e(0,0,0,1,1,0,0,2'b00));
    tick();                                           // c10
    chk("tmo_c10_err", e(0,0,0,1,1,0,1,2'b10));
    tick();                                           // c11
    chk("tmo_c11_idle", e(0,0,0,1,0,0,0,2'b10));

    // DIV, done in the same cycle as the timeout: done wins
    ifc.req = 1'b1; ifc.op = 1'b1;                    // c0
    tick(); ifc.req = 1'b0; ifc.op = 1'b0;            // c1
    repeat (8) tick();                                // c9
    ifc.div_done = 1'b1;
    tick(); ifc.div_done = 1'b0;                      // c10
    chk("prio_c10_write", e(0,0,1,1,1,1,0,2'b00));
    tick();                                           // c11
    chk("prio_c11_idle", e(0,0,0,1,0,0,0,2'b00));

    // MULT with a req pulse while busy
    ifc.req = 1'b1; ifc.op = 1'b0;                    // c0
    tick(); ifc.req = 1'b0;                           // c1
    chk("busyreq_c1_start", e(1,0,0,0,1,0,0,2'b00));
    tick(); tick(); ifc.req = 1'b1; ifc.op = 1'b1;    // c3
    tick(); ifc.req = 1'b0; ifc.op = 1'b0;            // c4
    chk("busyreq_c4_ignored", e(0,0,0,0,1,0,0,2'b00));
    ifc.mult_done = 1'b1;                             // held c4..c5
    tick();                                           // c5
    chk("busyreq_c5_write_once", e(0,0,1,0,1,1,0,2'b00));
    ifc.mult_done = 1'b0;
    tick();                                           // c6
    chk("busyreq_c6_idle", e(0,0,0,0,0,0,0,2'b00));
    tick();                                           // c7
    chk("busyreq_c7_no_restart", e(0,0,0,0,0,0,0,2'b00));

    // DIV aborted at cycle 3 together with div_done
    ifc.req = 1'b1; ifc.op = 1'b1;                    // c0
    tick(); ifc.req = 1'b0; ifc.op = 1'b0;            // c1
    chk("abort_c1_start", e(0,1,0,1,1,0,0,2'b00));
    tick(); tick();                                   // c3
    ifc.abort = 1'b1; ifc.div_done = 1'b1;
    chk("abort_c3_wait", e(0,0,0,1,1,0,0,2'b00));
    tick(); ifc.abort = 1'b0; ifc.div_done = 1'b0;    // c4
    chk("abort_c4_idle", e(0,0,0,1,0,0,0,2'b00));
    tick();                                           // c5
    chk("abort_c5_quiet", e(0,0,0,1,0,0,0,2'b00));

    // Asynchronous reset in WAIT, then a DIV with done at the earliest cycle
    ifc.req = 1'b1; ifc.op = 1'b0;                    // c0
    tick(); ifc.req = 1'b0;                           // c1
    tick();                                           // c2
    chk("rst_c2_wait", e(0,0,0,0,1,0,0,2'b00));
    #3 reset = 1'b0;
    #1;
    chk("rst_async_clear", e(0,0,0,0,0,0,0,2'b00));
    tick(); tick();
    @(negedge clk) reset = 1'b1;
    tick();
    ifc.req = 1'b1; ifc.op = 1'b1;                    // c0
    tick(); ifc.req = 1'b0; ifc.op = 1'b0;            // c1
    chk("rst_new_c1_start", e(0,1,0,1,1,0,0,2'b00));
    tick(); ifc.div_done = 1'b1;                      // c2
    tick(); ifc.div_done = 1'b0;                      // c3
    chk("rst_new_c3_write", e(0,0,1,1,1,1,0,2'b00));
    tick();                                           // c4
    chk("rst_new_c4_idle", e(0,0,0,1,0,0,0,2'b00));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
